// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 control unit: decodes the ROM instruction into the datapath control word and constant.
// Define LEGV8_ILLEGAL_TRAP_EN to make unlisted opcodes stop in S_HALT instead of executing as NOP.
module legv8_multicycle_control #(
  parameter int CW_W   = 29,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic [4:0]        status,
  output logic [CW_W-1:0]   control_word,
  output logic [DATA_W-1:0] constant,
  output logic              halted
);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_EX0  = 2'd1;
  localparam logic [1:0] S_EX1  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  logic [1:0] state, next_state;
  logic       take;

  logic [4:0] rd, rn, rm;
  assign rd = instruction[4:0];
  assign rn = instruction[9:5];
  assign rm = instruction[20:16];

  logic [DATA_W-1:0] imm12, dt9, br26, cb19;
  assign imm12 = {52'd0, instruction[21:10]};
  assign dt9   = {{55{instruction[20]}}, instruction[20:12]};
  assign br26  = {{36{instruction[25]}}, instruction[25:0], 2'b00};
  assign cb19  = {{43{instruction[23]}}, instruction[23:5], 2'b00};

  // Only the zero flag steers branching; the registered V/C/N/Z flags are not consumed here.
  logic unused_status;
  assign unused_status = ^status[4:1];

  logic       is_rtype, rt_sl, is_imm, is_stur, is_ldur, is_b, is_br, is_cb, cb_nz;
  logic [4:0] rt_fs, imm_fs;

  always_comb begin
    is_rtype = 1'b1;
    rt_sl    = 1'b0;
    rt_fs    = FS_ADD;
    case (instruction[31:21])
      11'h458: rt_fs = FS_ADD;
      11'h658: rt_fs = FS_SUB;
      11'h450: rt_fs = FS_AND;
      11'h550: rt_fs = FS_OR;
      11'h758: begin rt_fs = FS_SUB; rt_sl = 1'b1; end
      default: is_rtype = 1'b0;
    endcase
    is_imm  = (instruction[31:22] == 10'h244) || (instruction[31:22] == 10'h344);
    imm_fs  = instruction[30] ? FS_SUB : FS_ADD;
    is_stur = (instruction[31:21] == 11'h7C0);
    is_ldur = (instruction[31:21] == 11'h7C2);
    is_b    = (instruction[31:26] == 6'h05);
    is_br   = (instruction[31:21] == 11'h6B0);
    is_cb   = (instruction[31:25] == 7'h5A);
    cb_nz   = instruction[24];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
      take  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_EX0 && is_cb)
        take <= cb_nz ? ~status[0] : status[0];
    end
  end

  // EN_PC is never asserted by this instruction set, so the 29-bit word starts at EN_Mem (bit 28).
  logic       en_mem, en_alu, pcsel, bsel, sl, wm, wr;
  logic [1:0] ps;
  logic [4:0] fs, sb, sa, da;

  always_comb begin
    next_state = state;
    en_mem = 1'b0; en_alu = 1'b0; pcsel = 1'b0; bsel = 1'b0;
    sl = 1'b0; wm = 1'b0; wr = 1'b0;
    ps = 2'b00; fs = FS_AND; sb = 5'd0; sa = 5'd0; da = 5'd0;
    constant = '0;
    case (state)
      S_INIT: next_state = S_EX0;
      S_EX0: begin
        if (is_rtype || is_imm) begin
          sa = rn; sb = rm; da = rd;
          en_alu = 1'b1; wr = 1'b1; ps = 2'b01;
          sl = rt_sl;
          fs = is_imm ? imm_fs : rt_fs;
          if (is_imm) begin
            bsel = 1'b1;
            constant = imm12;
          end
        end else if (is_stur) begin
          sa = rn; sb = rd; bsel = 1'b1; fs = FS_ADD;
          constant = dt9; wm = 1'b1; ps = 2'b01;
        end else if (is_ldur) begin
          sa = rn; bsel = 1'b1; fs = FS_ADD; constant = dt9;
          next_state = S_EX1;
        end else if (is_b) begin
          pcsel = 1'b1; ps = 2'b11; constant = br26;
        end else if (is_br) begin
          sa = rn; ps = 2'b10;
        end else if (is_cb) begin
          sa = rd; sb = 5'd31; fs = FS_OR;
          next_state = S_EX1;
        end else begin
`ifdef LEGV8_ILLEGAL_TRAP_EN
          next_state = S_HALT;
`else
          ps = 2'b01;
`endif
        end
      end
      // The instruction is unchanged here because PC was held during S_EX0.
      S_EX1: begin
        next_state = S_EX0;
        if (is_ldur) begin
          sa = rn; bsel = 1'b1; fs = FS_ADD; constant = dt9;
          en_mem = 1'b1; wr = 1'b1; da = rd; ps = 2'b01;
        end else begin
          pcsel = 1'b1; constant = cb19;
          ps = take ? 2'b11 : 2'b01;
        end
      end
      default: next_state = S_HALT;
    endcase
  end

  assign control_word = {en_mem, en_alu, pcsel, bsel, sl, wm, wr, ps, fs, sb, sa, da};

`ifdef LEGV8_ILLEGAL_TRAP_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed self-checking bench for legv8_multicycle_control with hand-computed control words.
module tb_legv8_multicycle_control;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic [28:0] control_word;
  logic [63:0] constant;
  logic        halted;

  int checks = 0;
  int failures = 0;

  legv8_multicycle_control dut (
    .clock(clock),
    .reset(reset),
    .instruction(instruction),
    .status(status),
    .control_word(control_word),
    .constant(constant),
    .halted(halted)
  );

  always #5 clock = ~clock;

  // Field order {EN_Mem,EN_ALU,PCsel,Bsel,SL,WM,WR,PS,FS,SB,SA,DA}, DA at bit 0.
  function automatic logic [28:0] make_cw(input logic en_mem, en_alu, pcsel, bsel, sl, wm, wr,
                                          input logic [1:0] ps, input logic [4:0] fs, sb, sa, da);
    return {en_mem, en_alu, pcsel, bsel, sl, wm, wr, ps, fs, sb, sa, da};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [4:0] stat);
    @(negedge clock);
    instruction = instr;
    status = stat;
    #1;
  endtask

  task automatic nextCycle();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    instruction = 32'h8B030041;
    status = 5'd0;
    nextCycle();
    checkOutput("reset_cw", control_word, 0);
    checkOutput("reset_const", constant, 0);
    checkOutput("reset_halted", halted, 0);

    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("init_cw", control_word, 0);

    // ADD X1,X2,X3
    nextCycle();
    checkOutput("add_cw", control_word, make_cw(0,1,0,0,0,0,1,2'b01,5'b01000,5'd3,5'd2,5'd1));
    nextCycle();
    checkOutput("add_single_cycle", control_word, make_cw(0,1,0,0,0,0,1,2'b01,5'b01000,5'd3,5'd2,5'd1));

    // SUBS X1,X2,X3
    applyStimulus(32'hEB030041, 5'd0);
    checkOutput("subs_cw", control_word, make_cw(0,1,0,0,1,0,1,2'b01,5'b01001,5'd3,5'd2,5'd1));

    // ADDI X1,X2,#5
    applyStimulus(32'h91001441, 5'd0);
    checkOutput("addi_cw", control_word, make_cw(0,1,0,1,0,0,1,2'b01,5'b01000,5'd0,5'd2,5'd1));
    checkOutput("addi_const", constant, 64'd5);

    // LDUR X4,[X21,#8]
    applyStimulus(32'hF84082A4, 5'd0);
    checkOutput("ldur0_ps", control_word[21:20], 2'b00);
    checkOutput("ldur0_wr", control_word[22], 0);
    checkOutput("ldur0_en_mem", control_word[28], 0);
    checkOutput("ldur0_fs_bsel", {control_word[25], control_word[19:15]}, 6'b101000);
    checkOutput("ldur0_const", constant, 64'd8);
    nextCycle();
    checkOutput("ldur1_en_mem", control_word[28], 1);
    checkOutput("ldur1_wr", control_word[22], 1);
    checkOutput("ldur1_da", control_word[4:0], 5'd4);
    checkOutput("ldur1_ps", control_word[21:20], 2'b01);
    checkOutput("ldur1_const", constant, 64'd8);

    // LDUR with negative offset -8 exercises dt9 sign extension
    applyStimulus(32'hF85F82A4, 5'd0);
    checkOutput("ldur_neg_const", constant, 64'hFFFF_FFFF_FFFF_FFF8);
    checkOutput("ldur_neg_ps", control_word[21:20], 2'b00);
    nextCycle();

    // STUR X4,[X21,#8]
    applyStimulus(32'hF80082A4, 5'd0);
    checkOutput("stur_fields", {control_word[28:22], control_word[21:20], control_word[19:5]},
                {7'b0001010, 2'b01, 5'b01000, 5'd4, 5'd21});
    checkOutput("stur_const", constant, 64'd8);

    // CBZ X7,#+16 taken; zero flag drops in S_EX1 to prove the decision was latched
    applyStimulus(32'hB4000087, 5'b00001);
    checkOutput("cbz0_ps_wr", {control_word[22], control_word[21:20]}, 3'b000);
    checkOutput("cbz0_fs_sb_sa", control_word[19:5], {5'b00100, 5'd31, 5'd7});
    @(negedge clock);
    status = 5'd0;
    #1;
    checkOutput("cbz_taken_ps", control_word[21:20], 2'b11);
    checkOutput("cbz_taken_pcsel", control_word[26], 1);
    checkOutput("cbz_taken_const", constant, 64'd16);

    // CBZ not taken
    applyStimulus(32'hB4000087, 5'b00000);
    @(negedge clock);
    status = 5'b00001;
    #1;
    checkOutput("cbz_not_taken_ps", control_word[21:20], 2'b01);

    // CBNZ taken when zero flag low
    applyStimulus(32'hB5000087, 5'b00000);
    nextCycle();
    checkOutput("cbnz_taken_ps", control_word[21:20], 2'b11);

    // B #-4
    applyStimulus(32'h17FFFFFF, 5'd0);
    checkOutput("b_cw", control_word, make_cw(0,0,1,0,0,0,0,2'b11,5'd0,5'd0,5'd0,5'd0));
    checkOutput("b_const", constant, 64'hFFFF_FFFF_FFFF_FFFC);

    // BR X30
    applyStimulus(32'hD61F03C0, 5'd0);
    checkOutput("br_cw", control_word, make_cw(0,0,0,0,0,0,0,2'b10,5'd0,5'd0,5'd30,5'd0));

    // Reset during the S_EX1 of a load drops the write
    applyStimulus(32'hF84082A4, 5'd0);
    nextCycle();
    checkOutput("pre_reset_en_mem", control_word[28], 1);
    reset = 1'b1;
    #1;
    checkOutput("midreset_cw", control_word, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("midreset_init_cw", control_word, 0);
    nextCycle();
    checkOutput("after_reset_ldur0_ps", control_word[21:20], 2'b00);
    nextCycle();

    // Unlisted opcode
    applyStimulus(32'h00000000, 5'd0);
`ifdef LEGV8_ILLEGAL_TRAP_EN
    checkOutput("illegal_trap_cw", control_word, 0);
    nextCycle();
    checkOutput("halt_flag", halted, 1);
    checkOutput("halt_cw", control_word, 0);
    applyStimulus(32'h8B030041, 5'd0);
    checkOutput("halt_hold_cw", control_word, 0);
    reset = 1'b1;
    #1;
    checkOutput("halt_cleared", halted, 0);
    reset = 1'b0;
`else
    checkOutput("illegal_nop_cw", control_word, make_cw(0,0,0,0,0,0,0,2'b01,5'd0,5'd0,5'd0,5'd0));
    nextCycle();
    checkOutput("illegal_nop_again", control_word, make_cw(0,0,0,0,0,0,0,2'b01,5'd0,5'd0,5'd0,5'd0));
    checkOutput("illegal_halted", halted, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
